// File: rtl/triumph_wb_pkg.sv
// Shared definitions for the triumph register-file writeback arbiter.
// Round-robin mode is selected with the TRIUMPH_WB_RR_EN macro; fixed priority otherwise.
package triumph_wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } wb_state_e;

  // Bits needed to index n items, never less than 1.
  function automatic int idx_width(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/triumph_wb_if.sv
// Writeback requester bundle plus the registered regfile write port.
// Signal names mirror the arbiter's port list; the slave modport is the arbiter side.
interface triumph_wb_if
  import triumph_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
);

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_lock_i;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               stall_i;
  logic               wb_valid_o;
  logic [AW-1:0]      wb_addr_o;
  logic [DW-1:0]      wb_data_o;
  logic               lock_err_o;

  modport master (
    output req_valid_i, req_lock_i, req_addr_i, req_data_i, stall_i,
    input  req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, lock_err_o
  );

  modport slave (
    input  req_valid_i, req_lock_i, req_addr_i, req_data_i, stall_i,
    output req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, lock_err_o
  );

endinterface

// File: rtl/triumph_rr_arbiter.sv
// Combinational one-hot grant. TRIUMPH_WB_RR_EN selects round-robin starting after ptr_i;
// otherwise fixed priority with index 0 highest and ptr_i ignored.
module triumph_rr_arbiter
  import triumph_wb_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

`ifdef TRIUMPH_WB_RR_EN
  int slot;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    slot  = 0;
    for (int i = NREQ; i >= 1; i--) begin
      slot = (int'(ptr_i) + i) % NREQ;
      if (req_i[slot]) begin
        gnt_o       = '0;
        gnt_o[slot] = 1'b1;
        idx_o       = IW'(slot);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/triumph_wb_arbiter.sv
// Register-file write-port arbiter: per-requester valid/ready, locked multi-beat ownership
// with timeout, registered write output. Define TRIUMPH_WB_RR_EN for round-robin priority.
module triumph_wb_arbiter
  import triumph_wb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = REG_AW,
  parameter int DW       = REG_DW,
  parameter int LOCK_MAX = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  triumph_wb_if.slave bus
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(LOCK_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  wb_state_e       state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] ready;
  logic            lock_err;
  logic            timeout;
  logic            accept;
  logic [IW-1:0]   acc_idx;
  logic [AW-1:0]   acc_addr;

  triumph_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    ready      = '0;
    lock_err   = 1'b0;
    accept     = 1'b0;
    acc_idx    = owner_q;
    acc_addr   = '0;
    timeout    = (state_q == LOCKED) && (cnt_q >= CNT_LAST);

    if (!rst_i) begin
      // The lock counter keeps running through stalls but saturates at the timeout value.
      if (state_q == LOCKED && !timeout) cnt_d = cnt_q + 1'b1;

      if (!bus.stall_i) begin
        if (state_q == ARB) begin
          accept  = |gnt;
          acc_idx = gnt_idx;
        end else if (timeout) begin
          lock_err = 1'b1;
          state_d  = ARB;
          cnt_d    = '0;
        end else begin
          accept  = bus.req_valid_i[owner_q];
          acc_idx = owner_q;
        end

        if (accept) begin
          ready[acc_idx] = 1'b1;
          ptr_d          = acc_idx;
          acc_addr       = bus.req_addr_i[acc_idx*AW +: AW];
          // Writes to x0 are consumed but never reach the register file.
          if (acc_addr != '0) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = acc_addr;
            wb_data_d  = bus.req_data_i[acc_idx*DW +: DW];
          end
          if (state_q == ARB && bus.req_lock_i[acc_idx]) begin
            state_d = LOCKED;
            owner_d = acc_idx;
            cnt_d   = '0;
          end else if (state_q == LOCKED && !bus.req_lock_i[acc_idx]) begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q    <= ARB;
      owner_q    <= '0;
      ptr_q      <= IW'(NREQ - 1);
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_addr_o   = wb_addr_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.lock_err_o  = lock_err;

endmodule

// File: tb/tb_triumph_wb_arbiter.sv
// Directed bench for triumph_wb_arbiter (LOCK_MAX=4); priority expectations follow TRIUMPH_WB_RR_EN.
module tb_triumph_wb_arbiter;
  import triumph_wb_pkg::*;

  localparam int NREQ     = 3;
  localparam int AW       = REG_AW;
  localparam int DW       = REG_DW;
  localparam int LOCK_MAX = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  triumph_wb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  triumph_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after the rising edge; ready is sampled 1 ns later, registered outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    bus.req_addr_i[k*AW +: AW] = a;
    bus.req_data_i[k*DW +: DW] = d;
    bus.req_lock_i[k]          = lk;
  endtask

  task automatic test_reset();
    rst_i           = 1'b1;
    bus.stall_i     = 1'b0;
    bus.req_valid_i = '1;
    for (int k = 0; k < NREQ; k++) beat(k, AW'(k + 1), DW'(32'hAB00 + k), 1'b0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready_pre: got %b want 000", bus.req_ready_o);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (bus.req_ready_o !== 3'b000) begin
        n_fail++; $display("FAIL reset_ready c%0d: got %b want 000", c, bus.req_ready_o);
      end
      n_checks++;
      if (bus.wb_valid_o !== 1'b0 || bus.lock_err_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_outs c%0d: got valid=%b err=%b want 0/0", c, bus.wb_valid_o, bus.lock_err_o);
      end
      n_checks++;
      if (bus.wb_addr_o !== 5'd0 || bus.wb_data_o !== 32'd0) begin
        n_fail++; $display("FAIL reset_bus c%0d: got addr=%h data=%h want 0/0", c, bus.wb_addr_o, bus.wb_data_o);
      end
    end
    rst_i           = 1'b0;
    bus.req_valid_i = '0;
    tick();
  endtask

`ifdef TRIUMPH_WB_RR_EN
  task automatic test_priority();
    logic [NREQ-1:0] exp_rdy;
    bus.req_valid_i = 3'b111;
    for (int k = 0; k < NREQ; k++) beat(k, AW'(10 + k), DW'(32'h100 + k), 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_rdy = NREQ'(1) << (i % 3);
      #1;
      n_checks++;
      if (bus.req_ready_o !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready step%0d: got %b want %b", i, bus.req_ready_o, exp_rdy);
      end
      tick();
      n_checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== AW'(10 + i % 3) || bus.wb_data_o !== DW'(32'h100 + i % 3)) begin
        n_fail++; $display("FAIL rr_write step%0d: got v=%b a=%0d d=%h want 1/%0d/%h",
                           i, bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o, 10 + i % 3, 32'h100 + i % 3);
      end
    end
    bus.req_valid_i = '0;
    tick();
  endtask
`else
  task automatic test_priority();
    logic [NREQ-1:0] exp_rdy;
    logic [AW-1:0]   exp_addr;
    for (int k = 0; k < NREQ; k++) beat(k, AW'(10 + k), DW'(32'h100 + k), 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_i = (i < 3) ? 3'b110 : 3'b100;
      exp_rdy         = (i < 3) ? 3'b010 : 3'b100;
      exp_addr        = (i < 3) ? 5'd11 : 5'd12;
      #1;
      n_checks++;
      if (bus.req_ready_o !== exp_rdy) begin
        n_fail++; $display("FAIL fixed_ready step%0d: got %b want %b", i, bus.req_ready_o, exp_rdy);
      end
      tick();
      n_checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== exp_addr) begin
        n_fail++; $display("FAIL fixed_write step%0d: got v=%b a=%0d want 1/%0d", i, bus.wb_valid_o, bus.wb_addr_o, exp_addr);
      end
    end
    bus.req_valid_i = '0;
    tick();
  endtask
`endif

  task automatic test_lock();
    logic [NREQ-1:0] valid_t [4] = '{3'b010, 3'b011, 3'b011, 3'b001};
    logic            lock_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0]   lsu_t   [4] = '{5'd5, 5'd6, 5'd7, 5'd7};
    logic [NREQ-1:0] rdy_t   [4] = '{3'b010, 3'b010, 3'b010, 3'b001};
    logic [AW-1:0]   wa_t    [4] = '{5'd5, 5'd6, 5'd7, 5'd3};
    logic [DW-1:0]   wd_t    [4] = '{32'h5005, 32'h5006, 32'h5007, 32'h300};
    beat(0, 5'd3, 32'h300, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_i = valid_t[i];
      beat(1, lsu_t[i], DW'(32'h5000) + DW'(lsu_t[i]), lock_t[i]);
      #1;
      n_checks++;
      if (bus.req_ready_o !== rdy_t[i]) begin
        n_fail++; $display("FAIL lock_ready step%0d: got %b want %b", i, bus.req_ready_o, rdy_t[i]);
      end
      tick();
      n_checks++;
      if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== wa_t[i] || bus.wb_data_o !== wd_t[i]) begin
        n_fail++; $display("FAIL lock_write step%0d: got v=%b a=%0d d=%h want 1/%0d/%h",
                           i, bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o, wa_t[i], wd_t[i]);
      end
    end
    bus.req_valid_i = '0;
    beat(1, 5'd0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    bus.req_valid_i = 3'b100;
    beat(2, 5'd20, 32'h2020, 1'b1);
    beat(0, 5'd4, 32'h404, 1'b0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b100) begin
      n_fail++; $display("FAIL to_lock_ready: got %b want 100", bus.req_ready_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd20) begin
      n_fail++; $display("FAIL to_lock_write: got v=%b a=%0d want 1/20", bus.wb_valid_o, bus.wb_addr_o);
    end
    bus.req_valid_i = 3'b001;
    for (int c = 0; c < LOCK_MAX; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready_o !== 3'b000 || bus.lock_err_o !== (c == LOCK_MAX - 1)) begin
        n_fail++; $display("FAIL to_locked c%0d: got rdy=%b err=%b want 000/%0d",
                           c, bus.req_ready_o, bus.lock_err_o, c == LOCK_MAX - 1);
      end
      tick();
      n_checks++;
      if (bus.wb_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL to_nowrite c%0d: got %b want 0", c, bus.wb_valid_o);
      end
    end
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b001 || bus.lock_err_o !== 1'b0) begin
      n_fail++; $display("FAIL to_release: got rdy=%b err=%b want 001/0", bus.req_ready_o, bus.lock_err_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd4 || bus.wb_data_o !== 32'h404) begin
      n_fail++; $display("FAIL to_after_write: got v=%b a=%0d d=%h want 1/4/404", bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o);
    end
    bus.req_valid_i = '0;
    beat(2, 5'd0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_x0_stall();
    bus.req_valid_i = 3'b001;
    beat(0, 5'd0, 32'hDEAD, 1'b0);
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b001) begin
      n_fail++; $display("FAIL x0_ready: got %b want 001", bus.req_ready_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_nowrite: got %b want 0", bus.wb_valid_o);
    end
    beat(0, 5'd9, 32'h99, 1'b0);
    bus.stall_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (bus.req_ready_o !== 3'b000) begin
        n_fail++; $display("FAIL stall_ready c%0d: got %b want 000", c, bus.req_ready_o);
      end
      tick();
      n_checks++;
      if (bus.wb_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL stall_nowrite c%0d: got %b want 0", c, bus.wb_valid_o);
      end
    end
    bus.stall_i = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b001) begin
      n_fail++; $display("FAIL unstall_ready: got %b want 001", bus.req_ready_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd9 || bus.wb_data_o !== 32'h99) begin
      n_fail++; $display("FAIL unstall_write: got v=%b a=%0d d=%h want 1/9/99", bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o);
    end
    bus.req_valid_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_lock();
    bus.req_valid_i = 3'b010;
    beat(1, 5'd8, 32'h808, 1'b1);
    #1;
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd8) begin
      n_fail++; $display("FAIL mid_lock_write: got v=%b a=%0d want 1/8", bus.wb_valid_o, bus.wb_addr_o);
    end
    bus.req_valid_i = 3'b011;
    beat(0, 5'd2, 32'h22, 1'b0);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_ready: got %b want 000", bus.req_ready_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b0 || bus.wb_addr_o !== 5'd0 || bus.wb_data_o !== 32'd0) begin
      n_fail++; $display("FAIL mid_rst_outs: got v=%b a=%0d d=%h want 0/0/0", bus.wb_valid_o, bus.wb_addr_o, bus.wb_data_o);
    end
    rst_i           = 1'b0;
    bus.req_valid_i = 3'b001;
    #1;
    n_checks++;
    if (bus.req_ready_o !== 3'b001) begin
      n_fail++; $display("FAIL mid_rst_unlock: got %b want 001", bus.req_ready_o);
    end
    tick();
    n_checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_addr_o !== 5'd2) begin
      n_fail++; $display("FAIL mid_rst_write: got v=%b a=%0d want 1/2", bus.wb_valid_o, bus.wb_addr_o);
    end
    bus.req_valid_i = '0;
    tick();
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_lock_i  = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.stall_i     = 1'b0;
    rst_i           = 1'b1;
    test_reset();
    test_priority();
    test_lock();
    test_timeout();
    test_x0_stall();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
